// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types, default constants and width helpers for the
// multi-channel push-button debouncer.
package debounce_pkg;

    // Per-channel debounce state: STABLE means the output matches the settled
    // input; PENDING means a run of differing samples is being counted.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } db_state_e;

    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_STABLE_CNT  = 5;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_SAMPLE_DIV  = 1;
    localparam logic        DEF_IDLE_LEVEL  = 1'b1;

    // Width of the per-channel run counter; must hold the value STABLE_CNT.
    function automatic int unsigned cnt_width(input int unsigned stable_cnt);
        if (stable_cnt < 1) begin
            return 1;
        end
        return $clog2(stable_cnt + 1);
    endfunction

    // Width of the shared prescaler counter; at least one bit even when
    // every clock is a sample tick.
    function automatic int unsigned div_width(input int unsigned sample_div);
        if (sample_div <= 1) begin
            return 1;
        end
        return $clog2(sample_div);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced button bit.
//   clk, reset     : clock, asynchronous active-low reset
//   en             : debounce enable (0 clears the run counter, holds d_out)
//   tick           : shared sample strobe from the prescaler
//   d_raw          : raw asynchronous pin
//   d_out          : debounced level
//   press_pulse    : one-cycle pulse when d_out becomes ~IDLE_LEVEL
//   release_pulse  : one-cycle pulse when d_out becomes IDLE_LEVEL
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic        IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic tick,
    input  logic d_raw,
    output logic d_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned CW = cnt_width(STABLE_CNT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_c;

    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // Synchroniser chain; only its last stage is seen by the debounce logic.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_raw};
        s_c    = sync_q[SYNC_STAGES-1];
    end

    // Next-state, counter, level and pulse logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        if (!en) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                ST_STABLE: begin
                    if (s_c != out_q) begin
                        if (STABLE_CNT == 1) begin
                            // A single differing sample is already enough.
                            out_d     = s_c;
                            cnt_d     = '0;
                            press_d   = (s_c != IDLE_LEVEL);
                            release_d = (s_c == IDLE_LEVEL);
                        end else begin
                            state_d = ST_PENDING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_PENDING: begin
                    if (s_c == out_q) begin
                        // Input bounced back: abandon this run.
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if ((cnt_q + CW'(1)) == CW'(STABLE_CNT)) begin
                        state_d   = ST_STABLE;
                        cnt_d     = '0;
                        out_d     = s_c;
                        press_d   = (s_c != IDLE_LEVEL);
                        release_d = (s_c == IDLE_LEVEL);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= {SYNC_STAGES{IDLE_LEVEL}};
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            out_q     <= IDLE_LEVEL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign d_out         = out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent push-button debouncers sharing one
// sample-rate prescaler.
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   en             : debounce enable
//   D_in           : raw asynchronous button inputs
//   D_out          : debounced levels
//   press_pulse    : per-channel one-cycle pulse on becoming ~IDLE_LEVEL
//   release_pulse  : per-channel one-cycle pulse on becoming IDLE_LEVEL
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned STABLE_CNT  = DEF_STABLE_CNT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV,
    parameter logic        IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [N_CH-1:0] D_in,
    output logic [N_CH-1:0] D_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse
);

    localparam int unsigned PW = div_width(SAMPLE_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_c;

    // Shared sample strobe; wraps the prescaler on the terminal count.
    always_comb begin
        tick_c  = en && (presc_q == PW'(SAMPLE_DIV - 1));
        presc_d = presc_q;
        if (!en) begin
            presc_d = '0;
        end else if (tick_c) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // One debouncer per channel, all on the same tick.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .SYNC_STAGES (SYNC_STAGES),
            .IDLE_LEVEL  (IDLE_LEVEL)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .en            (en),
            .tick          (tick_c),
            .d_raw         (D_in[i]),
            .d_out         (D_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: two debouncers (sample divider 1 and 4) driven by the
// same pins, checked every cycle against a sample-history model, plus
// directed edge-count checks from hand-worked timelines.
module tb_debounce_multi;

    localparam int N   = 4;
    localparam int SC  = 5;
    localparam int SS  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] D_in;
    logic [3:0] out_a, press_a, rel_a;
    logic [3:0] out_b, press_b, rel_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    debounce_multi #(.N_CH(N), .STABLE_CNT(SC), .SYNC_STAGES(SS),
                     .SAMPLE_DIV(1), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .D_in(D_in),
        .D_out(out_a), .press_pulse(press_a), .release_pulse(rel_a));

    debounce_multi #(.N_CH(N), .STABLE_CNT(SC), .SYNC_STAGES(SS),
                     .SAMPLE_DIV(4), .IDLE_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .D_in(D_in),
        .D_out(out_b), .press_pulse(press_b), .release_pulse(rel_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pin value seen by the logic is the one captured SS edges
    // earlier; a level changes once the last SC tick samples since the
    // previous change (or enable) all disagree with it.
    int         divs [2] = '{1, 4};
    logic [3:0] m_out [2];
    logic [3:0] m_press [2];
    logic [3:0] m_rel [2];
    int         m_encyc [2];
    bit         m_q [2][4][$];
    logic [3:0] dhist [$];

    task automatic model_step();
        logic [3:0] s;
        bit         tick;
        bit         all_diff;
        if (reset !== 1'b1) begin
            dhist.delete();
            for (int k = 0; k < SS; k++) dhist.push_back(4'hF);
            for (int m = 0; m < 2; m++) begin
                m_out[m] = 4'hF; m_press[m] = '0; m_rel[m] = '0; m_encyc[m] = 0;
                for (int c = 0; c < N; c++) m_q[m][c].delete();
            end
            return;
        end
        s = dhist[0];
        void'(dhist.pop_front());
        dhist.push_back(D_in);
        for (int m = 0; m < 2; m++) begin
            m_press[m] = '0;
            m_rel[m]   = '0;
            if (en !== 1'b1) begin
                m_encyc[m] = 0;
                for (int c = 0; c < N; c++) m_q[m][c].delete();
            end else begin
                tick = ((m_encyc[m] % divs[m]) == divs[m] - 1);
                m_encyc[m]++;
                if (tick) begin
                    for (int c = 0; c < N; c++) begin
                        m_q[m][c].push_back(s[c]);
                        if (m_q[m][c].size() > SC) void'(m_q[m][c].pop_front());
                        all_diff = (m_q[m][c].size() == SC);
                        foreach (m_q[m][c][j]) if (m_q[m][c][j] == m_out[m][c]) all_diff = 0;
                        if (all_diff) begin
                            m_out[m][c] = s[c];
                            if (s[c] == 1'b0) m_press[m][c] = 1'b1;
                            else              m_rel[m][c]   = 1'b1;
                            m_q[m][c].delete();
                        end
                    end
                end
            end
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("a_dout",    out_a,   m_out[0]);
            chk("a_press",   press_a, m_press[0]);
            chk("a_release", rel_a,   m_rel[0]);
            chk("b_dout",    out_b,   m_out[1]);
            chk("b_press",   press_b, m_press[1]);
            chk("b_release", rel_b,   m_rel[1]);
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input logic [3:0] v);
        @(negedge clk);
        D_in = v;
        repeat (30) wait_edge();
    endtask

    int first_b;

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        D_in  = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dout", out_a, 4'hF);
        chk("rst_press", press_a, 4'h0);
        @(negedge clk);
        reset = 1'b1;

        // Idle after reset.
        for (int k = 0; k < 20; k++) begin
            wait_edge();
            chk("idle_dout", out_a, 4'hF);
            chk("idle_pulses", {press_a, rel_a}, 8'h00);
        end

        // Channel 0 press: edge 7 for divider 1, edges 19..22 for divider 4.
        @(negedge clk);
        D_in = 4'hE;
        first_b = 0;
        for (int k = 1; k <= 24; k++) begin
            wait_edge();
            if (k == 6) chk("press_e6_dout", out_a, 4'hF);
            if (k == 7) begin
                chk("press_e7_dout", out_a, 4'hE);
                chk("press_e7_pulse", press_a, 4'h1);
                chk("press_e7_rel", rel_a, 4'h0);
            end
            if (k == 8) chk("press_e8_pulse", press_a, 4'h0);
            if (first_b == 0 && out_b[0] == 1'b0) first_b = k;
        end
        chk("div4_window", 32'((first_b >= 19) && (first_b <= 22)), 32'd1);
        settle(4'hF);
        chk("settle_a", out_a, 4'hF);
        chk("settle_b", out_b, 4'hF);

        // Bounce on channel 1: 0 x4, 1 x1, then 0 held.
        @(negedge clk);
        D_in = 4'hD;
        for (int k = 1; k <= 14; k++) begin
            wait_edge();
            if (k == 11) chk("bounce_e11_dout", 32'(out_a[1]), 32'd1);
            if (k == 12) begin
                chk("bounce_e12_dout", 32'(out_a[1]), 32'd0);
                chk("bounce_e12_pulse", press_a, 4'h2);
            end
            if (k == 4) begin @(negedge clk); D_in = 4'hF; end
            if (k == 5) begin @(negedge clk); D_in = 4'hD; end
        end
        settle(4'hF);
        settle(4'h3);
        chk("both_pressed", out_a, 4'h3);

        // Simultaneous release of channels 2 and 3.
        @(negedge clk);
        D_in = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            wait_edge();
            if (k == 6) chk("rel_e6_dout", out_a, 4'h3);
            if (k == 7) begin
                chk("rel_e7_dout", out_a, 4'hF);
                chk("rel_e7_pulse", rel_a, 4'hC);
                chk("rel_e7_press", press_a, 4'h0);
            end
            if (k == 8) chk("rel_e8_pulse", rel_a, 4'h0);
        end
        settle(4'hF);

        // Reset in the middle of a count.
        @(negedge clk);
        D_in = 4'hE;
        repeat (5) wait_edge();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_dout", out_a, 4'hF);
        chk("midrst_pulse", press_a, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_edge();
            if (k == 6) chk("midrst_e6", out_a, 4'hF);
            if (k == 7) begin
                chk("midrst_e7", out_a, 4'hE);
                chk("midrst_e7_pulse", press_a, 4'h1);
            end
        end
        settle(4'hF);

        // Enable dropped in the middle of a count.
        @(negedge clk);
        D_in = 4'hE;
        repeat (5) wait_edge();
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_edge();
            chk("en0_pulse", press_a, 4'h0);
            chk("en0_dout", out_a, 4'hF);
        end
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_edge();
            if (k == 4) chk("en1_e4", out_a, 4'hF);
            if (k == 5) begin
                chk("en1_e5", out_a, 4'hE);
                chk("en1_e5_pulse", press_a, 4'h1);
            end
            if (k == 6) chk("en1_e6_pulse", press_a, 4'h0);
        end
        settle(4'hF);

        // Random pins, enable drops and occasional resets.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, (k < 2000) ? 7 : 39) == 0) D_in[c] = ~D_in[c];
            end
            if (en == 1'b1) begin
                if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                en = 1'b1;
            end
            reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        repeat (2) wait_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
